// File: rtl/frame_buffer_fetch.sv
// frame_buffer_fetch: reads a packed grayscale frame back from SRAM (four
// 8-bit pixels per 32-bit word) and streams it out one pixel at a time.
// Read requests are throttled by a credit count. A credit covers every word
// that has been requested but not yet fully unpacked, so the return FIFO
// never overflows and data_ready can simply follow the RUN state.
module frame_buffer_fetch #(
  parameter int          N_PIXEL         = 480000,
  parameter logic [17:0] BASE_ADDR       = 18'd0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        start_ack,
  output logic        done,
  input  logic        done_ack,
  output logic [17:0] addr,
  output logic        addr_valid,
  input  logic        addr_ready,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  pixel,
  output logic        pixel_valid,
  input  logic        pixel_ready
);

  localparam int CNT_W  = $clog2(N_PIXEL + 1);
  localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);

  localparam logic [CNT_W-1:0]  N_WORDS  = CNT_W'(N_PIXEL / 4);
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(N_PIXEL - 1);
  localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  req_idx;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CRED_W-1:0] credits;

  logic [31:0]       fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CRED_W-1:0] fifo_cnt;

  logic [31:0]       unpack_reg;
  logic [1:0]        byte_idx;

  logic              req_fire;
  logic              pix_fire;
  logic              word_done;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W-1:0]  req_idx_n;
  logic [CRED_W-1:0] credits_n;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The current pixel always sits in the top byte of the unpack register.
  assign pixel = unpack_reg[31:24];

  // Handshake decode and next request index / credit count.
  always_comb begin
    req_fire  = addr_valid & addr_ready;
    pix_fire  = pixel_valid & pixel_ready;
    word_done = pix_fire & (byte_idx == 2'd3);
    fifo_push = data_valid & data_ready;
    fifo_pop  = (state == RUN) & (fifo_cnt != '0) & (~pixel_valid | word_done);
    req_idx_n = req_fire ? req_idx + 1'b1 : req_idx;
    case ({req_fire, word_done})
      2'b10:   credits_n = credits + 1'b1;
      2'b01:   credits_n = credits - 1'b1;
      default: credits_n = credits;
    endcase
  end

  // Frame FSM with registered handshake and request outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      start_ack  <= 1'b0;
      done       <= 1'b0;
      data_ready <= 1'b0;
      addr_valid <= 1'b0;
      addr       <= BASE_ADDR;
      req_idx    <= '0;
      pix_cnt    <= '0;
      credits    <= '0;
    end else begin
      start_ack <= 1'b0;
      case (state)
        IDLE: begin
          addr_valid <= 1'b0;
          addr       <= BASE_ADDR;
          req_idx    <= '0;
          pix_cnt    <= '0;
          credits    <= '0;
          if (start) begin
            state      <= RUN;
            start_ack  <= 1'b1;
            data_ready <= 1'b1;
          end
        end
        RUN: begin
          req_idx    <= req_idx_n;
          credits    <= credits_n;
          addr       <= BASE_ADDR + 18'(req_idx_n);
          addr_valid <= (req_idx_n < N_WORDS) && (credits_n < MAX_CRED);
          if (pix_fire) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_PIX) begin
              state      <= DONE;
              done       <= 1'b1;
              data_ready <= 1'b0;
              addr_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          addr_valid <= 1'b0;
          if (done_ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return-word storage; only the pointers need clearing.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers plus the unpacker, which reloads without a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      unpack_reg  <= '0;
      byte_idx    <= '0;
      pixel_valid <= 1'b0;
    end else if (state != RUN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      unpack_reg  <= '0;
      byte_idx    <= '0;
      pixel_valid <= 1'b0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (fifo_pop) begin
        unpack_reg  <= fifo_mem[rd_ptr];
        byte_idx    <= 2'd0;
        pixel_valid <= 1'b1;
      end else if (pix_fire) begin
        unpack_reg <= {unpack_reg[23:0], 8'h00};
        byte_idx   <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          pixel_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_fetch.sv
// tb_frame_buffer_fetch: directed bench for frame_buffer_fetch with an SRAM
// model (2-cycle read latency) and a pixel scoreboard filled at frame start.
module tb_frame_buffer_fetch;

  localparam int          N_PIXEL = 32;
  localparam int          N_WORDS = N_PIXEL / 4;
  localparam int          MAX_OUT = 4;
  localparam logic [17:0] BASE    = 18'h100;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        start_ack;
  logic        done;
  logic        done_ack;
  logic [17:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        pixel_ready;

  frame_buffer_fetch #(
    .N_PIXEL(N_PIXEL),
    .BASE_ADDR(BASE),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .start_ack(start_ack),
    .done(done),
    .done_ack(done_ack),
    .addr(addr),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .data(data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .pixel(pixel),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready)
  );

  // 100 MHz free-running clock.
  always #5 clock = ~clock;

  logic [31:0] mem [N_WORDS];
  logic [7:0]  exp_pix [$];
  int          req_due [$];
  logic [17:0] req_addr [$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_pct = 100;
  bit          stall_addr = 0;
  bit          force_dv = 0;
  logic [17:0] exp_addr;
  int          acc_words;
  int          done_words;
  int          pix_seen;
  int          last_pix_cyc;
  int          start_ack_count;
  bit          prev_addr_stall = 0;
  logic [17:0] prev_addr;
  bit          prev_pix_stall = 0;
  logic [7:0]  prev_pix;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: observe at the falling edge, then drive the inputs the
  // next rising edge will sample and record the handshakes it will perform.
  task automatic applyStimulus();
    int idx;
    @(negedge clock);
    cyc++;
    if (prev_addr_stall) begin
      checkOutput("addr_hold", 32'(addr), 32'(prev_addr));
      checkOutput("addr_valid_hold", 32'(addr_valid), 1);
    end
    if (prev_pix_stall) begin
      checkOutput("pixel_hold", 32'(pixel), 32'(prev_pix));
    end
    if (start_ack === 1'b1) start_ack_count++;

    addr_ready  = !stall_addr;
    pixel_ready = ($urandom_range(99) < ready_pct);

    if (force_dv) begin
      data_valid = 1'b1;
      data       = 32'hCAFEF00D;
    end else if (req_due.size() > 0 && req_due[0] <= cyc) begin
      idx        = int'(req_addr[0]) - int'(BASE);
      data       = (idx >= 0 && idx < N_WORDS) ? mem[idx] : 32'hDEADBEEF;
      data_valid = 1'b1;
      void'(req_due.pop_front());
      void'(req_addr.pop_front());
    end else begin
      data_valid = 1'b0;
      data       = 32'h0;
    end

    if (addr_valid === 1'b1 && addr_ready) begin
      checkOutput("req_addr", 32'(addr), 32'(exp_addr));
      req_addr.push_back(addr);
      req_due.push_back(cyc + 2);
      exp_addr++;
      acc_words++;
    end
    if (pixel_valid === 1'b1 && pixel_ready) begin
      if (exp_pix.size() == 0) begin
        checkOutput("extra_pixel", 32'(pixel_valid), 0);
      end else begin
        checkOutput("pixel", 32'(pixel), 32'(exp_pix.pop_front()));
      end
      pix_seen++;
      last_pix_cyc = cyc;
      if (pix_seen % 4 == 0) done_words++;
    end
    checkOutput("outstanding_limit", 32'((acc_words - done_words) <= MAX_OUT), 1);

    prev_addr_stall = (addr_valid === 1'b1) && !addr_ready;
    prev_addr       = addr;
    prev_pix_stall  = (pixel_valid === 1'b1) && !pixel_ready;
    prev_pix        = pixel;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_start_ack"}, 32'(start_ack), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_addr"}, 32'(addr), 32'(BASE));
    checkOutput({tag, "_addr_valid"}, 32'(addr_valid), 0);
    checkOutput({tag, "_data_ready"}, 32'(data_ready), 0);
    checkOutput({tag, "_pixel"}, 32'(pixel), 0);
    checkOutput({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
  endtask

  // Loads the scoreboard with the whole frame and issues start.
  task automatic start_frame(input bit hold_start);
    exp_pix.delete();
    for (int w = 0; w < N_WORDS; w++) begin
      for (int b = 3; b >= 0; b--) exp_pix.push_back(mem[w][b*8 +: 8]);
    end
    exp_addr        = BASE;
    pix_seen        = 0;
    acc_words       = 0;
    done_words      = 0;
    start_ack_count = 0;
    start = 1'b1;
    applyStimulus();
    checkOutput("start_ack_pulse", 32'(start_ack), 1);
    checkOutput("addr_valid_at_ack", 32'(addr_valid), 0);
    start = hold_start;
    applyStimulus();
    checkOutput("addr_valid_rise", 32'(addr_valid), 1);
    checkOutput("first_addr", 32'(addr), 32'(BASE));
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      applyStimulus();
      n++;
    end
    checkOutput("done_seen", 32'(done), 1);
    ok = (done === 1'b1);
    if (ok) begin
      checkOutput("done_timing", 32'(cyc - last_pix_cyc), 1);
      checkOutput("pixel_count", 32'(pix_seen), 32'(N_PIXEL));
      checkOutput("pixel_valid_at_done", 32'(pixel_valid), 0);
    end
  endtask

  // Hard stop in case the design wedges somewhere no bounded wait covers.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  // Directed sequence.
  initial begin
    bit ok;
    int held;
    int n;

    mem[0] = 32'hAABBCCDD;
    mem[1] = 32'h11223344;
    for (int i = 2; i < N_WORDS; i++) mem[i] = 32'h0F1E2D3C + 32'(i) * 32'h01020304;

    reset = 1'b0; start = 1'b0; done_ack = 1'b0; addr_ready = 1'b1;
    data = 32'h0; data_valid = 1'b0; pixel_ready = 1'b1;

    $display("[TB] reset held with start pulsed");
    start = 1'b1;
    applyStimulus();
    check_reset_outputs("rst_a");
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    check_reset_outputs("rst_b");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("no_spurious_addr_valid", 32'(addr_valid), 0);
    end

    $display("[TB] basic frame");
    start_frame(1'b0);
    wait_done(ok);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (done === 1'b1) held++;
    end
    checkOutput("done_held", 32'(held), 10);
    done_ack = 1'b1;
    applyStimulus();
    done_ack = 1'b0;
    checkOutput("done_drop", 32'(done), 0);
    applyStimulus();
    checkOutput("idle_addr", 32'(addr), 32'(BASE));

    $display("[TB] backpressure frame, immediate done_ack");
    ready_pct = 30;
    start_frame(1'b0);
    wait_done(ok);
    done_ack = 1'b1;
    applyStimulus();
    done_ack = 1'b0;
    checkOutput("done_one_cycle", 32'(done), 0);
    ready_pct = 100;
    applyStimulus();

    $display("[TB] request stall");
    stall_addr = 1'b1;
    start_frame(1'b0);
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("stall_addr", 32'(addr), 32'(BASE));
    checkOutput("stall_addr_valid", 32'(addr_valid), 1);
    stall_addr = 1'b0;
    wait_done(ok);
    checkOutput("stall_addr_count", 32'(acc_words), 32'(N_WORDS));
    done_ack = 1'b1;
    applyStimulus();
    done_ack = 1'b0;
    applyStimulus();

    $display("[TB] data_valid in IDLE, then start held high");
    force_dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("idle_dv_pixel_valid", 32'(pixel_valid), 0);
    end
    force_dv = 1'b0;
    applyStimulus();
    checkOutput("idle_dv_pixel_valid_after", 32'(pixel_valid), 0);
    ready_pct = 60;
    start_frame(1'b1);
    wait_done(ok);
    checkOutput("start_ack_count", 32'(start_ack_count), 1);
    start = 1'b0;
    done_ack = 1'b1;
    applyStimulus();
    done_ack = 1'b0;
    ready_pct = 100;
    applyStimulus();

    $display("[TB] abort mid-frame with reset");
    start_frame(1'b0);
    n = 0;
    while (pix_seen < 5 && n < 500) begin
      applyStimulus();
      n++;
    end
    checkOutput("abort_reached_5", 32'(pix_seen >= 5), 1);
    applyStimulus();
    reset = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    exp_pix.delete();
    req_due.delete();
    req_addr.delete();
    acc_words = 0; done_words = 0;
    prev_addr_stall = 0; prev_pix_stall = 0;
    applyStimulus();
    check_reset_outputs("abort_hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("abort_no_addr_valid", 32'(addr_valid), 0);
    end
    start_frame(1'b0);
    wait_done(ok);
    done_ack = 1'b1;
    applyStimulus();
    done_ack = 1'b0;
    checkOutput("retrigger_done_drop", 32'(done), 0);
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
